wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, ALU write-back buffer entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive full-FIFO cycles before memory is throttled.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports alu_valid in 1, alu_rd in 5, alu_data in 32, alu_ready out 1: ALU result channel.
REQ-006 SHALL have ports mem_valid in 1, mem_rd in 5, mem_data in 32, mem_ready out 1: load-result channel.
REQ-007 SHALL have ports busC out 32, busCsel out 5, en out 1: the register bank's single write port.

Function
REQ-008 SHALL issue at most one register write per cycle; busC/busCsel/en registered, valid one cycle after selection.
REQ-009 SHALL transfer on a channel only when valid and ready are both high in the same cycle.
REQ-010 SHALL enqueue accepted ALU results into the FIFO; alu_ready = FIFO not full, from registered state only (no same-cycle pop credit).
REQ-011 SHALL give memory priority: accepted mem transfer is written next cycle; otherwise the FIFO head is popped and written.
REQ-012 SHALL drop transfers with rd = 0: accepted (ready honoured), never enqueued, en stays 0.
REQ-013 SHALL deassert mem_ready while any FIFO entry holds rd equal to mem_rd (nonzero), preserving write order.
REQ-014 SHALL count consecutive cycles with FIFO full; at count = STARVE_LIMIT, mem_ready = 0 for one cycle, forcing a pop; counter then clears.
REQ-015 SHALL clear the starvation counter on any cycle the FIFO is not full.
REQ-016 SHALL hold en = 0 in cycles with nothing selected; busC/busCsel hold their last values.
REQ-017 SHALL allow simultaneous enqueue and pop when not full; occupancy unchanged.
REQ-018 SHALL keep FIFO pointers wrap-around modulo FIFO_DEPTH with separate occupancy count (full/empty unambiguous).

Reset
REQ-019 SHALL on reset low, immediately: en = 0, busC = 0, busCsel = 0, FIFO empty, starvation counter 0.
REQ-020 SHALL drive alu_ready = 1 and mem_ready = 1 during and after reset (FIFO empty).
REQ-021 SHALL discard in-flight FIFO contents on reset mid-operation; no write issued in the release cycle.

Configuration
REQ-022 SHALL, with WB_FWD_EN defined, add ports fwd_sel in 5, fwd_hit out 1, fwd_data out 32: combinational lookup of youngest FIFO entry or registered output whose rd = fwd_sel (nonzero).
REQ-023 SHALL, without WB_FWD_EN, omit those ports and all lookup logic; other behaviour identical.

Structure
REQ-024 SHALL take REG_ADDR_W = 5, DATA_W = 32 and wb_entry_t {rd, data} from shared package cpu_pkg.
REQ-025 SHALL implement buffering in sub-module wb_fifo (push, pop, full, empty, head, entry array visible for match/forward).

Verification
REQ-026 SHALL cover: ALU only, rd=3 data=0xA5A5_0001 -> next cycle en=1, busCsel=3, busC=0xA5A5_0001.
REQ-027 SHALL cover: ALU rd=1 and mem rd=2 same cycle -> cycle+1 writes r2 (mem), cycle+2 writes r1.
REQ-028 SHALL cover: ALU rd=5 buffered, mem_valid rd=5 -> mem_ready=0 until r5 ALU write issued, then mem write follows.
REQ-029 SHALL cover: mem_valid held high, ALU fills FIFO (depth 2) -> after 4 full cycles mem_ready=0 one cycle, one FIFO pop.
REQ-030 SHALL cover: rd=0 on either channel -> accepted, en never asserted; reset asserted with 2 entries -> en=0, alu_ready=1, no later writes of them.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, write-back entry format
// and the write-port source selector used by the write-back arbiter.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // Which producer owns the register-file write port in a given cycle
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_ALU  = 2'd3
    } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-back buffer for ALU results. Circular storage with wrap-around
// pointers and a separate occupancy count, so full and empty are never
// ambiguous. The stored entries are also presented in age order (index 0 is
// the oldest) together with a per-position valid mask, letting the arbiter
// scan them for register hazards and forwarding.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output wb_entry_t             head,
    output wb_entry_t [DEPTH-1:0] entries,
    output logic [DEPTH-1:0]      valid
);

    wb_entry_t [DEPTH-1:0] store;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr];

    // Storage, pointers and occupancy; a reset throws away everything buffered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            store  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                store[wr_ptr] <= push_entry;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Rotate the storage into age order so position k is the k-th oldest entry
    always_comb begin
        entries = '0;
        valid   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            entries[k] = store[rd_ptr + PTR_W'(k)];
            valid[k]   = ((PTR_W+1)'(k) < count);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter. Merges the ALU result channel and the
// load-result channel onto the single register write port. Loads win the
// port; ALU results wait in wb_fifo, or flow straight through when the
// buffer is empty and no load claims the port. Writes to r0 are accepted and
// dropped. A load whose destination is still waiting in the buffer is held
// off to keep write order, and a buffer that stays full for STARVE_LIMIT
// cycles steals one cycle from the load channel to drain.
// Optional build macro WB_FWD_EN adds a combinational forwarding lookup port.
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  mem_ready,
    output logic [DATA_W-1:0]     busC,
    output logic [REG_ADDR_W-1:0] busCsel,
    output logic                  en
`ifdef WB_FWD_EN
    ,
    input  logic [REG_ADDR_W-1:0] fwd_sel,
    output logic                  fwd_hit,
    output logic [DATA_W-1:0]     fwd_data
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic                       fifo_full;
    logic                       fifo_empty;
    wb_entry_t                  fifo_head;
    wb_entry_t [FIFO_DEPTH-1:0] fifo_entries;
    logic [FIFO_DEPTH-1:0]      fifo_valid;
    logic                       fifo_push;
    logic                       fifo_pop;
    wb_entry_t                  alu_entry;
    wb_entry_t                  sel_entry;
    wb_src_t                    src;
    logic [CNT_W-1:0]           starve_cnt;
    logic                       throttle;
    logic                       hazard;
    logic                       alu_fire;
    logic                       mem_fire;

    assign throttle       = (starve_cnt == STARVE_MAX);
    assign alu_ready      = !fifo_full;
    assign mem_ready      = !hazard && !throttle;
    assign alu_fire       = alu_valid && alu_ready;
    assign mem_fire       = mem_valid && mem_ready;
    assign alu_entry.rd   = alu_rd;
    assign alu_entry.data = alu_data;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (alu_entry),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head),
        .entries    (fifo_entries),
        .valid      (fifo_valid)
    );

    // Hold off a load whose destination register still has a buffered ALU write
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (fifo_valid[k] && (fifo_entries[k].rd == mem_rd) && (mem_rd != '0)) begin
                hazard = 1'b1;
            end
        end
    end

    // Pick this cycle's writer: load first, then the oldest buffered result,
    // then a fresh ALU result flowing through an empty buffer. A dropped r0
    // load leaves the port free, so the buffer may drain in that cycle.
    always_comb begin
        src       = SRC_NONE;
        sel_entry = '0;
        fifo_pop  = 1'b0;
        if (mem_fire && (mem_rd != '0)) begin
            src            = SRC_MEM;
            sel_entry.rd   = mem_rd;
            sel_entry.data = mem_data;
        end else if (!fifo_empty) begin
            src       = SRC_FIFO;
            sel_entry = fifo_head;
            fifo_pop  = 1'b1;
        end else if (alu_fire && (alu_rd != '0)) begin
            src       = SRC_ALU;
            sel_entry = alu_entry;
        end
        fifo_push = alu_fire && (alu_rd != '0) && (src != SRC_ALU);
    end

    // Registered write port; data and address keep their last values when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en      <= 1'b0;
            busC    <= '0;
            busCsel <= '0;
        end else begin
            en <= (src != SRC_NONE);
            if (src != SRC_NONE) begin
                busC    <= sel_entry.data;
                busCsel <= sel_entry.rd;
            end
        end
    end

    // Count consecutive full-buffer cycles; clears when the buffer has room or after a throttle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!fifo_full || throttle) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

`ifdef WB_FWD_EN
    // Forward the youngest pending value for fwd_sel: buffered entries beat the write port
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_sel != '0) begin
            if (en && (busCsel == fwd_sel)) begin
                fwd_hit  = 1'b1;
                fwd_data = busC;
            end
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if (fifo_valid[k] && (fifo_entries[k].rd == fwd_sel)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = fifo_entries[k].data;
                end
            end
        end
    end
`endif

endmodule
